// File: rtl/ctrl_pkg.sv
// Shared types for the ctrl_seq sequencer: states, instruction fields,
// jump condition codes and flag bit positions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_A,
        DST_B,
        DST_MEM
    } dst_e;

    typedef enum logic [1:0] {
        BSRC_B,
        BSRC_LIT,
        BSRC_MEM,
        BSRC_JMP
    } bsrc_e;

    typedef enum logic [2:0] {
        C_JMP,
        C_JEQ,
        C_JNE,
        C_JLT,
        C_JGE,
        C_JCS,
        C_JVS,
        C_HALT
    } cond_e;

    typedef struct packed {
        logic [7:0] lit;
        logic [2:0] sel;
        dst_e       dst;
        bsrc_e      bsrc;
        logic       rsvd;
    } instr_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/ctrl_seq_branch_cond.sv
// Jump condition evaluation against latched ZNCV flags.
// HALT never reports taken; the sequencer handles it separately.
module branch_cond
    import ctrl_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            C_JMP:  taken = 1'b1;
            C_JEQ:  taken = flags[FLAG_Z];
            C_JNE:  taken = !flags[FLAG_Z];
            C_JLT:  taken = flags[FLAG_N];
            C_JGE:  taken = !flags[FLAG_N];
            C_JCS:  taken = flags[FLAG_C];
            C_JVS:  taken = flags[FLAG_V];
            C_HALT: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit ALU datapath.
// Optional ack watchdog: define CTRL_SEQ_ACK_TIMEOUT_EN.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [7:0]  imem_addr_o,
    input  logic [15:0] imem_data_i,
    output logic [2:0]  alu_sel_o,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    input  logic [7:0]  alu_out_i,
    input  logic [3:0]  alu_zncv_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [7:0]  dmem_addr_o,
    output logic [7:0]  dmem_wdata_o,
    input  logic [7:0]  dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [7:0]  reg_a_o,
    output logic [7:0]  reg_b_o,
    output logic [3:0]  flags_o,
    output logic        halt_o,
    output logic        err_o
);

    state_e     state, state_d;
    instr_t     ir, ir_d;
    logic [7:0] pc, pc_d, pc_inc;
    logic [7:0] reg_a, reg_a_d;
    logic [7:0] reg_b, reg_b_d;
    logic [7:0] wdata_q, wdata_d;
    logic [3:0] flags, flags_d;
    logic       taken;
    logic       timeout;
    logic       unused_bits;

    assign pc_inc = pc + 8'd1;
    assign unused_bits = ^{ir.rsvd, ACK_TIMEOUT[0]};

    branch_cond u_cond (
        .cond  (cond_e'(ir.sel)),
        .flags (flags),
        .taken (taken)
    );

`ifdef CTRL_SEQ_ACK_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          mem_wait;
    logic          err;

    assign mem_wait = (state == S_MEM_RD || state == S_MEM_WR)
                      && !dmem_ack_i;
    assign timeout  = mem_wait && (wait_cnt == CW'(ACK_TIMEOUT - 1));
    assign err_o    = err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= mem_wait ? wait_cnt + CW'(1) : '0;
            err      <= err | timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        ir_d       = ir;
        pc_d       = pc;
        reg_a_d    = reg_a;
        reg_b_d    = reg_b;
        flags_d    = flags;
        wdata_d    = wdata_q;
        alu_b_o    = reg_b;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        unique case (state)
            S_FETCH: begin
                ir_d    = instr_t'(imem_data_i);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (ir.bsrc == BSRC_LIT) alu_b_o = ir.lit;
                if (ir.bsrc == BSRC_JMP) begin
                    if (cond_e'(ir.sel) == C_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = taken ? ir.lit : pc_inc;
                        state_d = S_FETCH;
                    end
                end else if (ir.bsrc == BSRC_MEM) begin
                    state_d = S_MEM_RD;
                end else begin
                    flags_d = alu_zncv_i;
                    if (ir.dst == DST_MEM) begin
                        wdata_d = alu_out_i;
                        state_d = S_MEM_WR;
                    end else begin
                        if (ir.dst == DST_A) reg_a_d = alu_out_i;
                        if (ir.dst == DST_B) reg_b_d = alu_out_i;
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_MEM_RD: begin
                dmem_req_o = 1'b1;
                alu_b_o    = dmem_rdata_i;
                if (timeout) begin
                    state_d = S_HALT;
                end else if (dmem_ack_i) begin
                    flags_d = alu_zncv_i;
                    if (ir.dst == DST_MEM) begin
                        wdata_d = alu_out_i;
                        state_d = S_MEM_WR;
                    end else begin
                        if (ir.dst == DST_A) reg_a_d = alu_out_i;
                        if (ir.dst == DST_B) reg_b_d = alu_out_i;
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_MEM_WR: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = 1'b1;
                if (timeout) begin
                    state_d = S_HALT;
                end else if (dmem_ack_i) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_FETCH;
            ir      <= '0;
            pc      <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            flags   <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_d;
            ir      <= ir_d;
            pc      <= pc_d;
            reg_a   <= reg_a_d;
            reg_b   <= reg_b_d;
            flags   <= flags_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_addr_o  = pc;
    assign alu_sel_o    = ir.sel;
    assign alu_a_o      = reg_a;
    assign dmem_addr_o  = ir.lit;
    assign dmem_wdata_o = wdata_q;
    assign reg_a_o      = reg_a;
    assign reg_b_o      = reg_b;
    assign flags_o      = flags;
    assign halt_o       = (state == S_HALT);

endmodule
